// File: rtl/seg_pkg.sv
// Shared types for the seven-segment pattern decoder: segment codes, decode result and FSM states.
// Active-low segment order is {g,f,e,d,c,b,a}; a 0 bit means the segment is lit.
package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_A     = 7'b0001000;
   localparam seg_t SEG_B     = 7'b0000011;
   localparam seg_t SEG_C     = 7'b1000110;
   localparam seg_t SEG_D     = 7'b0100001;
   localparam seg_t SEG_E     = 7'b0000110;
   localparam seg_t SEG_F     = 7'b0001110;

   typedef struct packed {
      logic [3:0] value;
      logic       blank;
      logic       err;
   } seg_dec_t;

   typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} dec_state_e;

endpackage

// File: rtl/seg_pattern_decoder_if.sv
// Segment-sample input and decoded-digit valid/ready output of seg_pattern_decoder.
// master = the environment that drives the display bus and consumes digits; slave = the decoder.
interface seg_pattern_decoder_if;
   import seg_pkg::*;

   seg_t       seg_n;
   logic       seg_vld;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_value;
   logic       out_blank;
   logic       out_err;
   logic       overrun;

   modport master (
      output seg_n, seg_vld, out_ready,
      input  out_valid, out_value, out_blank, out_err, overrun
   );

   modport slave (
      input  seg_n, seg_vld, out_ready,
      output out_valid, out_value, out_blank, out_err, overrun
   );

endinterface

// File: rtl/seg_pattern_lut.sv
// Combinational inverse of the BCD-to-seven-segment table.
// Hex letters A..F decode to 10..15 only when HEX_DECODE_EN is defined; otherwise they flag err.
module seg_pattern_lut
   import seg_pkg::*;
(
   input  seg_t     seg_n,
   output seg_dec_t dec
);

   always_comb begin
      dec = '{value: 4'd0, blank: 1'b0, err: 1'b1};
      case (seg_n)
         SEG_0:     dec = '{value: 4'd0,  blank: 1'b0, err: 1'b0};
         SEG_1:     dec = '{value: 4'd1,  blank: 1'b0, err: 1'b0};
         SEG_2:     dec = '{value: 4'd2,  blank: 1'b0, err: 1'b0};
         SEG_3:     dec = '{value: 4'd3,  blank: 1'b0, err: 1'b0};
         SEG_4:     dec = '{value: 4'd4,  blank: 1'b0, err: 1'b0};
         SEG_5:     dec = '{value: 4'd5,  blank: 1'b0, err: 1'b0};
         SEG_6:     dec = '{value: 4'd6,  blank: 1'b0, err: 1'b0};
         SEG_7:     dec = '{value: 4'd7,  blank: 1'b0, err: 1'b0};
         SEG_8:     dec = '{value: 4'd8,  blank: 1'b0, err: 1'b0};
         SEG_9:     dec = '{value: 4'd9,  blank: 1'b0, err: 1'b0};
         SEG_BLANK: dec = '{value: 4'd0,  blank: 1'b1, err: 1'b0};
`ifdef HEX_DECODE_EN
         SEG_A:     dec = '{value: 4'd10, blank: 1'b0, err: 1'b0};
         SEG_B:     dec = '{value: 4'd11, blank: 1'b0, err: 1'b0};
         SEG_C:     dec = '{value: 4'd12, blank: 1'b0, err: 1'b0};
         SEG_D:     dec = '{value: 4'd13, blank: 1'b0, err: 1'b0};
         SEG_E:     dec = '{value: 4'd14, blank: 1'b0, err: 1'b0};
         SEG_F:     dec = '{value: 4'd15, blank: 1'b0, err: 1'b0};
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Glitch-filtering seven-segment snooper: a pattern must repeat STABLE_CNT valid samples before it is
// decoded and offered once on a single-entry valid/ready register. Optional macro: HEX_DECODE_EN.
module seg_pattern_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CNT = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   seg_pattern_decoder_if.slave bus
);

   localparam int             CW       = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CNT);
   localparam logic [1:0]     ST_IDLE   = 2'(IDLE);
   localparam logic [1:0]     ST_TRACK  = 2'(TRACK);
   localparam logic [1:0]     ST_LOCKED = 2'(LOCKED);

   logic [1:0]    state_reg, state_next;
   seg_t          cand_reg, cand_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   seg_t          last_reg;
   logic          last_vld_reg;
   logic          out_valid_reg;
   seg_dec_t      out_dec_reg;
   logic          overrun_reg;
   logic          accept;
   logic          emit;
   seg_dec_t      dec;

   seg_pattern_lut u_lut (
      .seg_n (bus.seg_n),
      .dec   (dec)
   );

   // A differing sample (or the first one after reset) always restarts the filter at count 1.
   always_comb begin
      state_next = state_reg;
      cand_next  = cand_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      if (bus.seg_vld) begin
         if (state_reg == ST_IDLE || bus.seg_n != cand_reg) begin
            cand_next = bus.seg_n;
            cnt_next  = CNT_ONE;
            if (STABLE_CNT == 1) begin
               accept     = 1'b1;
               state_next = ST_LOCKED;
            end else begin
               state_next = ST_TRACK;
            end
         end else if (state_reg == ST_TRACK) begin
            if (cnt_reg < CNT_MAX) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
            if (cnt_next == CNT_MAX) begin
               accept     = 1'b1;
               state_next = ST_LOCKED;
            end
         end
      end
   end

   // Re-acquiring the previously emitted pattern after a glitch is not a new digit.
   assign emit = accept && (!last_vld_reg || bus.seg_n != last_reg);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= ST_IDLE;
         cand_reg      <= SEG_BLANK;
         cnt_reg       <= '0;
         last_reg      <= SEG_BLANK;
         last_vld_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         out_dec_reg   <= '0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cand_reg  <= cand_next;
         cnt_reg   <= cnt_next;
         if (emit) begin
            last_reg     <= bus.seg_n;
            last_vld_reg <= 1'b1;
            if (!out_valid_reg || bus.out_ready) begin
               out_valid_reg <= 1'b1;
               out_dec_reg   <= dec;
            end else begin
               overrun_reg <= 1'b1;
            end
         end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_reg;
   assign bus.out_value = out_dec_reg.value;
   assign bus.out_blank = out_dec_reg.blank;
   assign bus.out_err   = out_dec_reg.err;
   assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Bench for seg_pattern_decoder: STABLE_CNT=3 and STABLE_CNT=1 instances share one stimulus stream
// and are each checked every cycle against a run-length reference model.
module tb_seg_pattern_decoder;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   em3 = 0;
   int   em1 = 0;

   always #5 clk = ~clk;

   seg_pattern_decoder_if bus3 ();
   seg_pattern_decoder_if bus1 ();

   seg_pattern_decoder #(.STABLE_CNT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
   seg_pattern_decoder #(.STABLE_CNT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

`ifdef HEX_DECODE_EN
   localparam bit HEX_EN = 1'b1;
`else
   localparam bit HEX_EN = 1'b0;
`endif

   localparam logic [6:0] REF_TBL [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Reference state: length of the current run of identical valid samples, plus the output register.
   int         k_cnt [2] = '{3, 1};
   int         run_len [2];
   logic [6:0] prev [2];
   bit         have_prev [2];
   logic [6:0] last [2];
   bit         last_vld [2];
   bit         mv [2];
   logic [3:0] mval [2];
   bit         mbl [2];
   bit         merr [2];
   bit         movr [2];

   function automatic logic [5:0] ref_decode(input logic [6:0] s);
      for (int v = 0; v < 16; v++) begin
         if (s == REF_TBL[v] && (v < 10 || HEX_EN)) return {4'(v), 2'b00};
      end
      if (s == 7'h7F) return 6'b0000_10;
      return 6'b0000_01;
   endfunction

   task automatic model_update(input int i, input logic [6:0] s, input logic v, input logic r,
                               input logic rn);
      bit acc;
      logic [5:0] d;
      if (!rn) begin
         run_len[i] = 0; have_prev[i] = 0; last_vld[i] = 0; last[i] = 7'h7F;
         mv[i] = 0; mval[i] = 0; mbl[i] = 0; merr[i] = 0; movr[i] = 0;
         return;
      end
      acc = 0;
      if (v) begin
         if (have_prev[i] && s == prev[i]) begin
            if (run_len[i] <= k_cnt[i]) run_len[i]++;
         end else begin
            run_len[i] = 1;
         end
         prev[i] = s;
         have_prev[i] = 1;
         acc = (run_len[i] == k_cnt[i]);
      end
      if (acc && (!last_vld[i] || s != last[i])) begin
         last[i] = s;
         last_vld[i] = 1;
         if (!mv[i] || r) begin
            d = ref_decode(s);
            mv[i] = 1; mval[i] = d[5:2]; mbl[i] = d[1]; merr[i] = d[0];
         end else begin
            movr[i] = 1;
         end
      end else if (mv[i] && r) begin
         mv[i] = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("d3_valid", {3'b0, bus3.out_valid}, {3'b0, mv[0]});
      chk("d3_overrun", {3'b0, bus3.overrun}, {3'b0, movr[0]});
      if (mv[0]) begin
         chk("d3_value", bus3.out_value, mval[0]);
         chk("d3_blank", {3'b0, bus3.out_blank}, {3'b0, mbl[0]});
         chk("d3_err", {3'b0, bus3.out_err}, {3'b0, merr[0]});
      end
      chk("d1_valid", {3'b0, bus1.out_valid}, {3'b0, mv[1]});
      chk("d1_overrun", {3'b0, bus1.overrun}, {3'b0, movr[1]});
      if (mv[1]) begin
         chk("d1_value", bus1.out_value, mval[1]);
         chk("d1_blank", {3'b0, bus1.out_blank}, {3'b0, mbl[1]});
         chk("d1_err", {3'b0, bus1.out_err}, {3'b0, merr[1]});
      end
      if (bus3.out_valid) em3++;
      if (bus1.out_valid) em1++;
   endtask

   // Check the state reached so far, then drive the inputs for the next rising edge.
   task automatic step(input logic [6:0] s, input logic v, input logic r, input logic rn);
      @(negedge clk);
      check_all();
      bus3.seg_n = s; bus3.seg_vld = v; bus3.out_ready = r;
      bus1.seg_n = s; bus1.seg_vld = v; bus1.out_ready = r;
      reset = rn;
      model_update(0, s, v, r, rn);
      model_update(1, s, v, r, rn);
      $display("[TB] t=%0t seg_n=%b vld=%0b rdy=%0b rst_n=%0b", $time, s, v, r, rn);
   endtask

   task automatic rep(input logic [6:0] s, input int n, input logic r);
      for (int j = 0; j < n; j++) step(s, 1'b1, r, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] pat;
      logic [6:0] alt;
      bus3.seg_n = 7'h7F; bus3.seg_vld = 0; bus3.out_ready = 0;
      bus1.seg_n = 7'h7F; bus1.seg_vld = 0; bus1.out_ready = 0;
      model_update(0, 7'h7F, 0, 0, 0);
      model_update(1, 7'h7F, 0, 0, 0);

      step(7'h7F, 0, 0, 0);
      step(7'h7F, 0, 0, 0);
      chk("rst_valid", {3'b0, bus3.out_valid}, 4'd0);
      chk("rst_value", bus3.out_value, 4'd0);
      chk("rst_flags", {1'b0, bus3.out_blank, bus3.out_err, bus3.overrun}, 4'd0);

      // Digit 2 for three samples.
      rep(7'b0100100, 3, 1);
      step(7'h7F, 0, 1, 1);
      chk("t1_value", bus3.out_value, 4'd2);
      step(7'h7F, 0, 1, 1);

      // Glitch inside the filter window, then a long hold.
      em3 = 0;
      rep(7'b0110000, 2, 1);
      rep(7'b0100100, 1, 1);
      rep(7'b0110000, 13, 1);
      step(7'h7F, 0, 1, 1);
      chk("t2_emissions", 4'(em3), 4'd1);

      // Overrun with a stalled consumer.
      rep(7'b1111000, 3, 0);
      rep(7'b0000000, 3, 0);
      step(7'h7F, 0, 0, 1);
      chk("t3_held", bus3.out_value, 4'd7);
      step(7'h7F, 0, 1, 1);
      step(7'h7F, 0, 1, 1);
      chk("t3_sticky", {3'b0, bus3.overrun}, 4'd1);

      // Hex letter A and blank.
      rep(7'b0001000, 3, 1);
      step(7'h7F, 0, 1, 1);
      chk("t4_hex_err", {3'b0, bus3.out_err}, {3'b0, ~HEX_EN});
      rep(7'b1111111, 3, 1);
      step(7'h7F, 0, 1, 1);
      chk("t4_blank", {3'b0, bus3.out_blank}, 4'd1);

      // Interleaved strobe, then reset in the middle of tracking.
      step(7'b0010000, 1, 1, 1); step(7'b0010000, 0, 1, 1);
      step(7'b0010000, 1, 1, 1); step(7'b0010000, 0, 1, 1);
      step(7'b0010000, 1, 1, 1);
      step(7'h7F, 0, 1, 1);
      chk("t5_value", bus3.out_value, 4'd9);
      rep(7'b0011001, 2, 1);
      step(7'b0011001, 1, 1, 0);
      rep(7'b0011001, 3, 1);
      step(7'h7F, 0, 1, 1);
      step(7'h7F, 0, 1, 1);

      // Alternating 1/4 on every sample: the STABLE_CNT=1 instance emits each one.
      em1 = 0;
      for (int j = 0; j < 8; j++) step((j % 2 == 0) ? 7'b1111001 : 7'b0011001, 1, 1, 1);
      step(7'h7F, 0, 1, 1);
      chk("t6_emissions", 4'(em1), 4'd8);

      // Randomised traffic with sticky patterns, occasional stalls and rare resets.
      pat = REF_TBL[0];
      for (int j = 0; j < 400; j++) begin
         if ($urandom_range(0, 9) < 3) begin
            case ($urandom_range(0, 3))
               0: pat = 7'h7F;
               1: begin alt = 7'($urandom); pat = alt; end
               default: pat = REF_TBL[$urandom_range(0, 15)];
            endcase
         end
         step(pat, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 99) != 0));
      end
      step(7'h7F, 0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
